// File: rtl/step_channels.sv
// step_channels: N-channel step/dir pulse generator on the picorv32 bus; STEP_CHANNELS_IRQ_EN adds irq_out and CTRL.irq_mask.
module step_channels #(
  parameter int CHANNELS = 12,
  parameter int CNT_SIZE = 32,
  parameter int DIV_SIZE = 16,
  parameter int PULSE_WIDTH = 4,
  parameter logic [31:0] BASE_ADDR = 32'h10000100
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                mem_valid_in,
  input  logic [31:0]         mem_addr_in,
  input  logic [31:0]         mem_wdata_in,
  input  logic [3:0]          mem_wstrb_in,
  output logic [31:0]         mem_rdata_out,
  output logic                mem_ready_out,
  output logic [CHANNELS-1:0] step_out,
  output logic [CHANNELS-1:0] dir_out,
  output logic [CHANNELS-1:0] driver_en_n_out
`ifdef STEP_CHANNELS_IRQ_EN
  ,
  output logic                irq_out
`endif
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [DIV_SIZE:0] PW = (DIV_SIZE+1)'(PULSE_WIDTH);
  localparam logic [DIV_SIZE:0] MIN_P = (DIV_SIZE+1)'(2*PULSE_WIDTH);
  localparam logic [DIV_SIZE:0] ONE = (DIV_SIZE+1)'(1);
`ifdef STEP_CHANNELS_IRQ_EN
  localparam bit IRQ = 1'b1;
  logic [CHANNELS-1:0] irq_v;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic sel, ack, wr;
  logic [3:0] idx;
  logic [1:0] rsel;
  logic [31:0] rd [16];
  logic unused_addr;
  assign unused_addr = &{1'b0, mem_addr_in[1:0]};
  assign sel = mem_valid_in && mem_addr_in[31:8] == BASE_ADDR[31:8];
  assign ack = sel && !mem_ready_out;
  assign wr = ack && |mem_wstrb_in;
  assign idx = mem_addr_in[7:4];
  assign rsel = mem_addr_in[3:2];
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      mem_ready_out <= 1'b0;
      mem_rdata_out <= '0;
    end else begin
      mem_ready_out <= ack;
      mem_rdata_out <= (ack && !(|mem_wstrb_in)) ? rd[idx] : '0;
    end
  for (genvar c = 0; c < 16; c++) begin : ch
    if (c >= CHANNELS) begin : none
      assign rd[c] = '0;
    end else begin : chan
      state_t st;
      logic en, dir, dout, done, mask, step, we, idle;
      logic [CNT_SIZE-1:0] steps;
      logic [DIV_SIZE-1:0] div;
      logic [DIV_SIZE:0] cnt, period;
      assign we = wr && idx == 4'(c);
      assign idle = st == IDLE;
      // steps doubles as the remaining count, so an aborted run leaves it readable
      always_ff @(posedge clk_in or negedge reset_n_in)
        if (!reset_n_in) begin
          st <= IDLE;
          en <= 1'b0;
          dir <= 1'b0;
          dout <= 1'b0;
          done <= 1'b0;
          mask <= 1'b0;
          step <= 1'b0;
          steps <= '0;
          div <= '0;
          cnt <= '0;
          period <= '0;
        end else begin
          if (!idle) cnt <= cnt + ONE;
          if (st == HIGH && cnt == PW) begin
            st <= LOW;
            step <= 1'b0;
            steps <= steps - CNT_SIZE'(1);
          end
          if (st == LOW && cnt == period) begin
            cnt <= ONE;
            st <= steps != 0 ? HIGH : IDLE;
            step <= steps != 0;
            if (steps == 0) done <= 1'b1;
          end
          if (we && rsel == 2'd0) begin
            en <= mem_wdata_in[0];
            mask <= IRQ && mem_wdata_in[5];
            if (mem_wdata_in[4]) done <= 1'b0;
            if (mem_wdata_in[3]) begin
              st <= IDLE;
              step <= 1'b0;
            end
            if (idle) dir <= mem_wdata_in[1];
            if (idle && mem_wdata_in[2] && !mem_wdata_in[3]) begin
              if (steps != 0) begin
                st <= HIGH;
                step <= 1'b1;
                cnt <= ONE;
                period <= {1'b0, div} < MIN_P ? MIN_P : {1'b0, div};
                dout <= mem_wdata_in[1];
                done <= 1'b0;
              end else done <= 1'b1;
            end
          end
          if (we && idle && rsel == 2'd1) steps <= mem_wdata_in[CNT_SIZE-1:0];
          if (we && idle && rsel == 2'd2) div <= mem_wdata_in[DIV_SIZE-1:0];
        end
      assign rd[c] = rsel == 2'd0 ? {26'b0, mask, 3'b0, dir, en} :
                     rsel == 2'd1 ? 32'(steps) :
                     rsel == 2'd2 ? 32'(div) : {30'b0, done, !idle};
      assign step_out[c] = step;
      assign dir_out[c] = dout;
      assign driver_en_n_out[c] = ~en;
`ifdef STEP_CHANNELS_IRQ_EN
      assign irq_v[c] = done & mask;
`endif
    end
  end
`ifdef STEP_CHANNELS_IRQ_EN
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) irq_out <= 1'b0;
    else irq_out <= |irq_v;
`endif
endmodule
